register_dump_unit: RTL and testbench
=====================================

# register_dump_unit

Sequential reader for the processor register file: on a start pulse, walks a contiguous range of architectural registers through one register-file read port and streams each `{address, data}` pair out over a valid/ready debug interface. It sits beside the register file and shares a read port with the debug path. It is the consumer of what the datapath writes into the register file.

## Interface
- `DATA_WIDTH`, 64, register width
- `ADDR_WIDTH`, 5, register address width (32 registers)

- `clock`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high
- `start`  in  1  request pulse; sampled only in IDLE
- `first_reg`  in  ADDR_WIDTH  first register to dump; sampled with `start`
- `last_reg`  in  ADDR_WIDTH  last register to dump, inclusive; sampled with `start`
- `rf_read_address`  out  ADDR_WIDTH  drives the register-file read address
- `rf_read_data`  in  DATA_WIDTH  combinational read data returned for `rf_read_address`
- `out_valid`  out  1  beat available
- `out_ready`  in  1  sink accepts the beat
- `out_address`  out  ADDR_WIDTH  register index of the current beat
- `out_data`  out  DATA_WIDTH  register contents of the current beat
- `busy`  out  1  high from the cycle after an accepted `start` until DONE is left
- `done`  out  1  one-cycle pulse marking the end of a dump
- `checksum`  out  DATA_WIDTH  present only with `REG_DUMP_CHECKSUM_EN`

## Operation
- States: IDLE, READ, SEND, DONE.
- IDLE: if `start`=1 and `first_reg`<=`last_reg`, latch `ptr`=`first_reg`, latch `last`=`last_reg`, go to READ. If `start`=1 and `first_reg`>`last_reg`, go to DONE with no beats. `start` outside IDLE is ignored.
- READ: drive `rf_read_address`=`ptr`. Capture `rf_read_data` into `out_data` and `ptr` into `out_address`. Go to SEND.
- SEND: `out_valid`=1. `out_address` and `out_data` are held stable until `out_ready`=1.
  - On handshake with `ptr`==`last`, go to DONE.
  - On handshake otherwise, `ptr`=`ptr`+1 and go to READ.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- Pointer: `ptr` never wraps, because `last`<=31 is enforced at start. A range of 31..31 produces a single beat.
- x0 is read like any other register. The register file returns 0 for it.
- Data is a snapshot taken in READ. A register-file write landing after capture is not reflected in the held beat. A write landing before the READ cycle's edge is reflected.

## Timing
- Reset values: state IDLE; `out_valid`, `busy`, `done`=0; `rf_read_address`, `out_address`, `out_data`, `checksum`=0.
- `start` at edge N gives READ during cycle N+1 and `out_valid`=1 from cycle N+2.
- Throughput is 2 cycles per beat with `out_ready` tied high. A dump of k registers takes 2k+1 cycles from start to the `done` pulse.
- `out_valid` never drops without a handshake. Reset is the only exception.
- Reset asserted mid-dump aborts immediately: outputs return to reset values, no `done` pulse, and the partial stream is discarded by the sink.

## Configuration
- `REG_DUMP_CHECKSUM_EN` defined:
  - `checksum` is the XOR of every accepted `out_data` in the current dump.
  - It clears on an accepted `start` and is valid while `done`=1.
  - It holds its value until the next accepted `start`.
- `REG_DUMP_CHECKSUM_EN` undefined: no `checksum` port and no accumulator logic. All other behaviour is identical.

## Structure
- Shared package `reg_dump_pkg` holds:
  - the state enum (IDLE/READ/SEND/DONE);
  - `REG_COUNT`=32;
  - default `DATA_WIDTH`/`ADDR_WIDTH` constants, reused by the register file and debug path.
- Single module; no sub-module is warranted. The output holding register is part of the state machine.

## Test plan
- Preload x5=10, x3=25, then start with range 3..5 and `out_ready`=1 -> beats (3,25), (4,0), (5,10) in order, then one `done` pulse 7 cycles after start.
- Range 0..0 with x0 write of 99 attempted earlier -> single beat (0,0), then `done`.
- Range 3..5 with `out_ready` low for 4 cycles on the second beat -> beat (4,0) held stable throughout, no skipped or duplicated beats.
- `first_reg`=6, `last_reg`=2 -> no `out_valid`, `done` one cycle after start, `busy` high only that cycle.
- Reset asserted during SEND of beat 2 -> `out_valid`, `busy` and `done` go to 0 immediately; a fresh start afterwards dumps the full range.
- With `REG_DUMP_CHECKSUM_EN`, dump of 3..5 (25, 0, 10) -> `checksum`=25^10=19 during `done`. A second start clears it before accumulating.

Source files
------------

// File: rtl/reg_dump_pkg.sv
// reg_dump_pkg: shared constants and state encoding for the register dump path.
package reg_dump_pkg;
  localparam int REG_COUNT = 32;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_ADDR_WIDTH = 5;
  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} dumpState;
endpackage

// File: rtl/register_dump_unit.sv
// register_dump_unit: streams {address, data} for a register range over valid/ready.
// Optional XOR checksum of accepted beats with REG_DUMP_CHECKSUM_EN.
module register_dump_unit
  import reg_dump_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] first_reg,
  input  logic [ADDR_WIDTH-1:0] last_reg,
  output logic [ADDR_WIDTH-1:0] rf_read_address,
  input  logic [DATA_WIDTH-1:0] rf_read_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_address,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  done
`ifdef REG_DUMP_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] checksum
`endif
);
  dumpState state, nextState;
  logic [ADDR_WIDTH-1:0] ptr, last;
  logic handshake, accept;
  assign handshake = state == SEND && out_ready;
  assign accept = state == IDLE && start;
  assign rf_read_address = ptr;
  assign out_valid = state == SEND;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb
    nextState = state == IDLE ? (start ? (first_reg <= last_reg ? READ : DONE) : IDLE)
              : state == READ ? SEND
              : state == SEND ? (out_ready ? (ptr == last ? DONE : READ) : SEND)
              : IDLE;
  // the output holding register is loaded only in READ, so the beat is a snapshot
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      last <= '0;
      out_address <= '0;
      out_data <= '0;
    end else begin
      state <= nextState;
      if (accept) begin
        ptr <= first_reg;
        last <= last_reg;
      end
      if (state == READ) begin
        out_address <= ptr;
        out_data <= rf_read_data;
      end
      if (handshake && ptr != last) ptr <= ptr + 1'b1;
    end
`ifdef REG_DUMP_CHECKSUM_EN
  always_ff @(posedge clock or posedge reset)
    if (reset) checksum <= '0;
    else if (accept) checksum <= '0;
    else if (handshake) checksum <= checksum ^ out_data;
`endif
endmodule

// File: tb/tb_register_dump_unit.sv
// tb_register_dump_unit: directed and randomized dumps checked against a range/snapshot model.
module tb_register_dump_unit;
  import reg_dump_pkg::*;
  logic clock = 0, reset = 1, start = 0, out_ready = 0;
  logic [4:0] first_reg = 0, last_reg = 0;
  logic [4:0] rf_read_address, out_address;
  logic [63:0] rf_read_data, out_data;
  logic out_valid, busy, done;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [63:0] checksum;
`endif
  logic [63:0] regs [REG_COUNT];
  int total = 0, bad = 0;

  register_dump_unit dut (
    .clock(clock), .reset(reset), .start(start), .first_reg(first_reg), .last_reg(last_reg),
    .rf_read_address(rf_read_address), .rf_read_data(rf_read_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_address(out_address), .out_data(out_data), .busy(busy), .done(done)
`ifdef REG_DUMP_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clock = ~clock;
  assign rf_read_data = rf_read_address == 5'd0 ? 64'd0 : regs[rf_read_address];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] regValue(input int i);
    return i == 0 ? 64'd0 : regs[i];
  endfunction

  task automatic checkIdleOutputs(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rdaddr"}, rf_read_address, 0);
    check({tag, "_addr"}, out_address, 0);
    check({tag, "_data"}, out_data, 0);
`ifdef REG_DUMP_CHECKSUM_EN
    check({tag, "_cksum"}, checksum, 0);
`endif
  endtask

  task automatic runDump(input logic [4:0] f, input logic [4:0] l, input int stallBeat, input int stallLen);
    logic [4:0] expAddr[$];
    logic [63:0] expData[$];
    logic [63:0] expXor = 0;
    int n, beats = 0, stall = 0, edges = 0, expEdges;
    bit gotDone = 0, pend = 0;
    if (f <= l)
      for (int i = f; i <= l; i++) begin
        expAddr.push_back(i[4:0]);
        expData.push_back(regValue(i));
        expXor ^= regValue(i);
      end
    n = expAddr.size();
    expEdges = 2 * n + 1 + ((stallBeat >= 0 && stallBeat < n) ? stallLen : 0);
    @(negedge clock);
    start = 1; first_reg = f; last_reg = l; out_ready = 0;
    @(negedge clock);
    start = 0; edges = 1;
    check("busyAfterStart", busy, 1);
    if (n > 0) check("readAddr", rf_read_address, f);
    while (!gotDone && edges < 200) begin
      if (pend) check("validHeld", out_valid, 1);
      pend = 0;
      if (done) begin
        gotDone = 1;
        start = 0;
        out_ready = 0;
        check("doneTiming", edges, expEdges);
        check("beatCount", beats, n);
        check("validAtDone", out_valid, 0);
`ifdef REG_DUMP_CHECKSUM_EN
        check("checksum", checksum, expXor);
`endif
      end else begin
        start = 1'($urandom_range(0, 1));
        first_reg = 5'($urandom);
        last_reg = 5'($urandom);
        if (out_valid) begin
          if (beats < n) begin
            check("beatAddr", out_address, expAddr[beats]);
            check("beatData", out_data, expData[beats]);
          end else check("extraBeat", beats, n);
          if (beats == stallBeat && stall < stallLen) begin
            out_ready = 0;
            stall++;
            pend = 1;
            if (beats < n && expAddr[beats] != 0) regs[expAddr[beats]] = ~regs[expAddr[beats]];
          end else begin
            out_ready = 1;
            beats++;
          end
        end else out_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clock);
      edges++;
    end
    start = 0;
    out_ready = 0;
    check("doneSeen", gotDone, 1);
    check("donePulse", done, 0);
    check("busyAfterDone", busy, 0);
  endtask

  initial begin
    int w;
    for (int i = 0; i < REG_COUNT; i++) regs[i] = 0;
    @(negedge clock);
    checkIdleOutputs("reset");
    reset = 0;
    regs[5] = 10;
    regs[3] = 25;
    runDump(3, 5, -1, 0);
    regs[0] = 99;
    runDump(0, 0, -1, 0);
    runDump(3, 5, 1, 4);
    regs[4] = 0;
    runDump(6, 2, -1, 0);
    @(negedge clock);
    start = 1; first_reg = 3; last_reg = 5; out_ready = 1;
    @(negedge clock);
    start = 0;
    w = 0;
    while (!(out_valid && out_address == 5'd4) && w < 20) begin
      @(negedge clock);
      w++;
    end
    out_ready = 0;
    check("reachBeat2", w < 20, 1);
    #1 reset = 1;
    #1 checkIdleOutputs("midReset");
    @(negedge clock);
    reset = 0;
    @(negedge clock);
    check("noDoneAfterAbort", done, 0);
    runDump(3, 5, -1, 0);
    runDump(3, 5, 0, 2);
    runDump(31, 31, -1, 0);
    runDump(0, 31, 5, 3);
    for (int k = 0; k < 10; k++) begin
      logic [4:0] a, b;
      for (int i = 0; i < REG_COUNT; i++) regs[i] = {$urandom, $urandom};
      a = 5'($urandom);
      b = 5'($urandom);
      if (k % 4 != 3 && a > b) {a, b} = {b, a};
      runDump(a, b, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
